// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one forward key expansion per key, then one
// decryption round per clock with round keys regenerated backwards from rk10.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // Entry 0 sits in the top byte, so the bit index is 8*(255-a)+7.
    assign y = TABLE[{~a, 3'b111} -: 8];
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign y = TABLE[{~a, 3'b111} -: 8];
endmodule

module aes_inv_cipher_iter #(
    parameter int DATA_W    = 128,
    parameter int KEY_LEN   = 128,
    parameter int NO_ROUNDS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid_in,
    input  logic [KEY_LEN-1:0] cipher_key,
    output logic               key_ready_out,
    input  logic               data_valid_in,
    input  logic [DATA_W-1:0]  cipher_text,
    output logic               data_ready_out,
    output logic               valid_out,
    output logic [DATA_W-1:0]  plain_text
);
    typedef enum logic [1:0] {IDLE, KEYEXP, READY, DEC} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q;
    logic [KEY_LEN-1:0] key_q, rk10_q;
    logic [DATA_W-1:0]  blk_q;
    logic               load_key, accept, finish;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    // Byte i of the block lives at bits [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    // Key path: the four forward S-boxes serve RotWord(w3) while expanding and
    // RotWord(w3^w2) while walking the schedule backwards.
    logic [31:0]  w0, w1, w2, w3, p0, p1, p2, p3, f0, f1, f2, f3;
    logic [31:0]  sbox_in, sub_word, rcon_word;
    logic [127:0] rk_fwd, rk_prev;

    assign {w0, w1, w2, w3} = key_q;
    assign p3        = w3 ^ w2;
    assign p2        = w2 ^ w1;
    assign p1        = w1 ^ w0;
    assign sbox_in   = (state_q == DEC) ? {p3[23:0], p3[31:24]} : {w3[23:0], w3[31:24]};
    assign rcon_word = {rcon(cnt_q), 24'h000000};
    assign p0        = w0 ^ sub_word ^ rcon_word;
    assign f0        = w0 ^ sub_word ^ rcon_word;
    assign f1        = w1 ^ f0;
    assign f2        = w2 ^ f1;
    assign f3        = w3 ^ f2;
    assign rk_fwd    = {f0, f1, f2, f3};
    assign rk_prev   = {p0, p1, p2, p3};

    for (genvar i = 0; i < 4; i++) begin : g_key_sbox
        aes_sbox u_sbox (.a(sbox_in[8*i +: 8]), .y(sub_word[8*i +: 8]));
    end

    logic [127:0] isr, isb, ark, round_out;

    assign isr = inv_shift_rows(blk_q);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (.a(isr[8*i +: 8]), .y(isb[8*i +: 8]));
    end

    assign ark       = isb ^ rk_prev;
    assign round_out = (cnt_q == 4'd1) ? ark : inv_mix_columns(ark);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d  = state_q;
        load_key = 1'b0;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid_in) begin
                    load_key = 1'b1;
                    state_d  = KEYEXP;
                end
            end
            KEYEXP: begin
                if (cnt_q == 4'(NO_ROUNDS)) state_d = READY;
            end
            READY: begin
                if (key_valid_in) begin
                    load_key = 1'b1;
                    state_d  = KEYEXP;
                end else if (data_valid_in) begin
                    accept  = 1'b1;
                    state_d = DEC;
                end
            end
            DEC: begin
                if (cnt_q == 4'd1) begin
                    finish  = 1'b1;
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            key_q      <= '0;
            rk10_q     <= '0;
            blk_q      <= '0;
            valid_out  <= 1'b0;
            plain_text <= '0;
        end else begin
            state_q   <= state_d;
            valid_out <= finish;
            if (load_key) begin
                key_q <= cipher_key;
                cnt_q <= 4'd1;
            end else if (state_q == KEYEXP) begin
                key_q <= rk_fwd;
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'(NO_ROUNDS)) rk10_q <= rk_fwd;
            end else if (accept) begin
                blk_q <= cipher_text ^ rk10_q;
                key_q <= rk10_q;
                cnt_q <= 4'(NO_ROUNDS);
            end else if (state_q == DEC) begin
                blk_q <= round_out;
                key_q <= rk_prev;
                cnt_q <= cnt_q - 4'd1;
                if (finish) plain_text <= round_out;
            end
        end
    end

    assign key_ready_out  = (state_q == IDLE) || (state_q == READY);
    assign data_ready_out = (state_q == READY);
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 C.1 and Appendix B vectors.

module tb_aes_inv_cipher_iter;
    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid_in;
    logic [127:0] cipher_key;
    logic         key_ready_out;
    logic         data_valid_in;
    logic [127:0] cipher_text;
    logic         data_ready_out;
    logic         valid_out;
    logic [127:0] plain_text;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_inv_cipher_iter dut (
        .clk            (clk),
        .reset          (reset),
        .key_valid_in   (key_valid_in),
        .cipher_key     (cipher_key),
        .key_ready_out  (key_ready_out),
        .data_valid_in  (data_valid_in),
        .cipher_text    (cipher_text),
        .data_ready_out (data_ready_out),
        .valid_out      (valid_out),
        .plain_text     (plain_text)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic load_key(input logic [127:0] k, input string name);
        int n;
        @(negedge clk);
        key_valid_in = 1'b1;
        cipher_key   = k;
        @(negedge clk);
        key_valid_in = 1'b0;
        n = 0;
        while (!data_ready_out && n < 30) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n !== 10) begin
            fails++;
            $display("FAIL %s keyexp_cycles: got %0d want 10", name, n);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!data_ready_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!data_ready_out) begin
            tests++;
            fails++;
            $display("FAIL %s wait_ready: timed out", name);
        end
    endtask

    task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp, input string name);
        int lat;
        wait_ready(name);
        data_valid_in = 1'b1;
        cipher_text   = ct;
        @(negedge clk);
        data_valid_in = 1'b0;
        lat = 0;
        for (int j = 1; j <= 20 && lat == 0; j++) begin
            @(negedge clk);
            if (valid_out) lat = j;
        end
        tests++;
        if (lat !== 10) begin
            fails++;
            $display("FAIL %s latency: got %0d want 10", name, lat);
        end
        tests++;
        if (plain_text !== exp) begin
            fails++;
            $display("FAIL %s plain_text: got %h want %h", name, plain_text, exp);
        end
        @(negedge clk);
        tests++;
        if (valid_out !== 1'b0 || plain_text !== exp) begin
            fails++;
            $display("FAIL %s pulse_hold: valid_out=%b pt=%h want 0/%h", name, valid_out, plain_text, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tests++;
        if (valid_out !== 1'b0 || plain_text !== 128'h0) begin
            fails++;
            $display("FAIL reset_outputs: valid_out=%b pt=%h want 0/0", valid_out, plain_text);
        end
        tests++;
        if (key_ready_out !== 1'b1 || data_ready_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: key_ready=%b data_ready=%b want 1/0", key_ready_out, data_ready_out);
        end
    endtask

    task automatic test_idle_ignores_data();
        logic bad;
        bad = 1'b0;
        data_valid_in = 1'b1;
        cipher_text   = CT_C1;
        repeat (15) begin
            @(negedge clk);
            if (valid_out || data_ready_out || !key_ready_out) bad = 1'b1;
        end
        data_valid_in = 1'b0;
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL idle_ignores_data: activity seen=%b want 0", bad);
        end
    endtask

    task automatic test_fips_c1();
        load_key(KEY_C1, "c1");
        decrypt(CT_C1, PT_C1, "c1");
    endtask

    task automatic test_fips_b();
        load_key(KEY_B, "appb");
        tests++;
        if (dut.rk10_q !== RK10_B) begin
            fails++;
            $display("FAIL appb_rk10: got %h want %h", dut.rk10_q, RK10_B);
        end
        decrypt(CT_B, PT_B, "appb");
    endtask

    task automatic test_back_to_back(input logic [127:0] k, input logic [127:0] ct,
                                     input logic [127:0] exp, input string name);
        int acc [4];
        int vld [4];
        int n_acc, n_vld;
        logic pt_bad;
        load_key(k, name);
        n_acc  = 0;
        n_vld  = 0;
        pt_bad = 1'b0;
        data_valid_in = 1'b1;
        cipher_text   = ct;
        for (int i = 0; i < 40; i++) begin
            if (data_ready_out && data_valid_in && n_acc < 4) begin
                acc[n_acc] = cyc + 1;
                n_acc++;
            end
            @(negedge clk);
            if (n_acc >= 2) data_valid_in = 1'b0;
            if (valid_out && n_vld < 4) begin
                vld[n_vld] = cyc;
                n_vld++;
                if (plain_text !== exp) pt_bad = 1'b1;
            end
        end
        data_valid_in = 1'b0;
        tests++;
        if (n_acc !== 2 || n_vld !== 2) begin
            fails++;
            $display("FAIL %s b2b_counts: accepts=%0d valids=%0d want 2/2", name, n_acc, n_vld);
        end else begin
            tests++;
            if (acc[1] - acc[0] !== 11 || vld[0] - acc[0] !== 10 || vld[1] - acc[1] !== 10) begin
                fails++;
                $display("FAIL %s b2b_spacing: acc_gap=%0d lat0=%0d lat1=%0d want 11/10/10",
                         name, acc[1] - acc[0], vld[0] - acc[0], vld[1] - acc[1]);
            end
        end
        tests++;
        if (pt_bad !== 1'b0) begin
            fails++;
            $display("FAIL %s b2b_plain_text: last pt=%h want %h", name, plain_text, exp);
        end
    endtask

    task automatic test_same_key_twice();
        load_key(KEY_C1, "same_key_1");
        load_key(KEY_C1, "same_key_2");
        decrypt(CT_C1, PT_C1, "same_key");
    endtask

    task automatic test_priority_and_key_change();
        int n;
        logic seen;
        wait_ready("priority");
        key_valid_in  = 1'b1;
        cipher_key    = KEY_B;
        data_valid_in = 1'b1;
        cipher_text   = CT_C1;
        @(negedge clk);
        key_valid_in  = 1'b0;
        data_valid_in = 1'b0;
        tests++;
        if (key_ready_out !== 1'b0 || data_ready_out !== 1'b0) begin
            fails++;
            $display("FAIL priority_state: key_ready=%b data_ready=%b want 0/0", key_ready_out, data_ready_out);
        end
        n = 0;
        seen = 1'b0;
        while (!data_ready_out && n < 30) begin
            @(negedge clk);
            n++;
            if (valid_out) seen = 1'b1;
        end
        tests++;
        if (n !== 10 || seen !== 1'b0) begin
            fails++;
            $display("FAIL priority_reload: keyexp=%0d valid_seen=%b want 10/0", n, seen);
        end
        decrypt(CT_B, PT_B, "key_change");
    endtask

    task automatic test_drop_during_dec();
        int n_vld;
        logic pt_bad;
        wait_ready("drop");
        data_valid_in = 1'b1;
        cipher_text   = CT_B;
        @(negedge clk);
        data_valid_in = 1'b0;
        n_vld  = 0;
        pt_bad = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            if (j == 3) begin
                data_valid_in = 1'b1;
                cipher_text   = CT_C1;
            end
            @(negedge clk);
            data_valid_in = 1'b0;
            if (valid_out) begin
                n_vld++;
                if (plain_text !== PT_B) pt_bad = 1'b1;
            end
        end
        tests++;
        if (n_vld !== 1 || pt_bad !== 1'b0) begin
            fails++;
            $display("FAIL drop_during_dec: valids=%0d pt=%h want 1/%h", n_vld, plain_text, PT_B);
        end
    endtask

    task automatic test_reset_mid_dec();
        logic seen_valid, seen_ready;
        wait_ready("reset_mid");
        data_valid_in = 1'b1;
        cipher_text   = CT_B;
        @(negedge clk);
        data_valid_in = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (key_ready_out !== 1'b1 || data_ready_out !== 1'b0 || plain_text !== 128'h0 || valid_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_dec: key_ready=%b data_ready=%b valid=%b pt=%h want 1/0/0/0",
                     key_ready_out, data_ready_out, valid_out, plain_text);
        end
        seen_valid = 1'b0;
        seen_ready = 1'b0;
        data_valid_in = 1'b1;
        cipher_text   = CT_B;
        repeat (20) begin
            @(negedge clk);
            if (valid_out) seen_valid = 1'b1;
            if (data_ready_out) seen_ready = 1'b1;
        end
        data_valid_in = 1'b0;
        tests++;
        if (seen_valid !== 1'b0 || seen_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_key_block: valid_seen=%b ready_seen=%b want 0/0", seen_valid, seen_ready);
        end
    endtask

    initial begin
        reset         = 1'b1;
        key_valid_in  = 1'b0;
        cipher_key    = '0;
        data_valid_in = 1'b0;
        cipher_text   = '0;
        test_reset();
        test_idle_ignores_data();
        test_fips_c1();
        test_fips_b();
        test_back_to_back(KEY_C1, CT_C1, PT_C1, "b2b_c1");
        test_back_to_back(KEY_B, CT_B, PT_B, "b2b_appb");
        test_same_key_twice();
        test_priority_and_key_change();
        test_drop_during_dec();
        test_reset_mid_dec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
